// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU word sequencer and its 1-bit cell.
//   - Opcode encodings (cell CTRL and word-level op share one encoding)
//   - OP_MAX_SUPPORTED: highest opcode with a word-level meaning
//   - Sequencer FSM state type
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOTA = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  localparam logic [3:0] OP_MAX_SUPPORTED = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_word_seq_alu_1.sv
// alu_1: combinational 1-bit ALU cell.
// Ports:
//   a, b  : operand bits
//   ctrl  : 4-bit opcode (alu_pkg encoding)
//   y     : y[0] = result bit (half result for add/sub),
//           y[1] = carry generate (add) / borrow generate (sub), else 0
// Carry/borrow propagation across bits is done by the caller.
module alu_1
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [3:0] ctrl,
  output logic [1:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      OP_AND:  y[0] = a & b;
      OP_OR:   y[0] = a | b;
      OP_NOTA: y[0] = ~a;
      OP_NAND: y[0] = ~(a & b);
      OP_NOR:  y[0] = ~(a | b);
      OP_XOR:  y[0] = a ^ b;
      OP_XNOR: y[0] = ~(a ^ b);
      OP_ADD: begin
        y[0] = a ^ b;
        y[1] = a & b;
      end
      OP_SUB: begin
        y[0] = a ^ b;
        y[1] = ~a & b;
      end
      OP_MUL:  y[0] = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_word_seq.sv
// alu_word_seq: bit-serial word sequencer in front of the 1-bit ALU cell.
// Accepts {in_a, in_b, in_op} on a valid/ready handshake, streams operand
// bits LSB-first through alu_1 (one bit per clock), and presents the
// assembled word plus flags on an output valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : request handshake; in_a, in_b, in_op payload
//   out_valid/out_ready   : result handshake
//   out_y                 : result word
//   out_c                 : carry (add) / borrow (sub), else 0
//   out_z                 : out_y is zero
//   out_err               : unsupported opcode
//   out_ovf               : signed overflow for add/sub
// Optional feature: define ALU_WORD_SEQ_OVF_EN to compute out_ovf; when
// undefined the port is tied to 0 and no overflow register is built.
module alu_word_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_z,
  output logic             out_err,
  output logic             out_ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             cflag_q, cflag_d;
  logic             z_q, z_d;
  logic             err_q, err_d;
`ifdef ALU_WORD_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [1:0] cell_y;
  logic       res_bit;
  logic       c_nx;
  logic       supported;
  logic       arith;

  alu_1 u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .ctrl (op_q),
    .y    (cell_y)
  );

  // Per-bit result and carry/borrow ripple around the half-result cell.
  always_comb begin
    supported = (op_q <= OP_MAX_SUPPORTED);
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    res_bit   = 1'b0;
    c_nx      = c_q;
    case (op_q)
      OP_ADD: begin
        res_bit = cell_y[0] ^ c_q;
        c_nx    = cell_y[1] | (cell_y[0] & c_q);
      end
      OP_SUB: begin
        res_bit = cell_y[0] ^ c_q;
        c_nx    = cell_y[1] | (~cell_y[0] & c_q);
      end
      default: begin
        res_bit = supported ? cell_y[0] : 1'b0;
        c_nx    = c_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    res_d    = res_q;
    cflag_d  = cflag_q;
    z_d      = z_q;
    err_d    = err_q;
`ifdef ALU_WORD_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          cnt_d   = '0;
          c_d     = 1'b0;
          res_d   = '0;
          cflag_d = 1'b0;
          z_d     = 1'b0;
          err_d   = 1'b0;
`ifdef ALU_WORD_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nx;
        res_d = {res_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          z_d     = ~|res_d;
          cflag_d = arith ? c_nx : 1'b0;
          err_d   = ~supported;
`ifdef ALU_WORD_SEQ_OVF_EN
          // c_q here is the carry/borrow into the MSB, c_nx the one out of it.
          ovf_d   = arith ? (c_q ^ c_nx) : 1'b0;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cflag_q     <= 1'b0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_WORD_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cflag_q     <= cflag_d;
      z_q         <= z_d;
      err_q       <= err_d;
`ifdef ALU_WORD_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = res_q;
  assign out_c     = cflag_q;
  assign out_z     = z_q;
  assign out_err   = err_q;
`ifdef ALU_WORD_SEQ_OVF_EN
  assign out_ovf   = ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule
